// File: rtl/model_output_aligner.sv
// model_output_aligner
//
// Pairs results from a golden reference model (GRM) with results from the
// design under test (DUT) so that a downstream checker always compares
// matching transactions. GRM results usually arrive earlier than the DUT
// results, so they are held in a DEPTH-entry FIFO until the DUT catches up.
//
// Handshake: both input streams are valid-only. There is no backpressure,
// so a result counts as delivered in every cycle where its *_out_valid is
// high. chk_valid is a one-cycle pulse, and the checker must accept it
// unconditionally.
//
// Ports
//   g_clk, g_resetn             clock; asynchronous active-low reset
//   grm_out_valid, grm_*        incoming GRM result {result, rd_wen, rd_addr, rd_data}
//   dut_out_valid, dut_*        incoming DUT result, same fields
//   chk_valid                   aligned pair valid, 1 cycle after the pairing edge
//   chk_dut_*, chk_grm_*        aligned DUT / GRM fields, held while chk_valid is low
//   pending                     number of GRM entries buffered (0..DEPTH)
//   err_overflow                GRM push was dropped because the FIFO was full (sticky)
//   err_underflow               DUT result arrived with nothing to pair (sticky)
//   err_timeout                 oldest entry waited TIMEOUT cycles (sticky)
module model_output_aligner #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     grm_out_valid,
  input  logic [2:0]               grm_result,
  input  logic                     grm_rd_wen,
  input  logic [4:0]               grm_rd_addr,
  input  logic [31:0]              grm_rd_data,
  input  logic                     dut_out_valid,
  input  logic [2:0]               dut_result,
  input  logic                     dut_rd_wen,
  input  logic [4:0]               dut_rd_addr,
  input  logic [31:0]              dut_rd_data,
  output logic                     chk_valid,
  output logic [2:0]               chk_dut_result,
  output logic                     chk_dut_rd_wen,
  output logic [4:0]               chk_dut_rd_addr,
  output logic [31:0]              chk_dut_rd_data,
  output logic [2:0]               chk_grm_result,
  output logic                     chk_grm_rd_wen,
  output logic [4:0]               chk_grm_rd_addr,
  output logic [31:0]              chk_grm_rd_data,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err_overflow,
  output logic                     err_underflow,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The wait counter is at least 10 bits and grows if TIMEOUT needs more.
  localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [PW-1:0] PFULL = PW'(DEPTH);

  typedef struct packed {
    logic [2:0]  result;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PW-1:0]   count;
  logic [PW-1:0]   count_nxt;
  logic [TW-1:0]   wait_cnt;
  logic [TW-1:0]   wait_nxt;
  entry_t          chk_dut_q;
  entry_t          chk_grm_q;

  entry_t grm_in;
  entry_t dut_in;
  entry_t pair_grm;
  logic   empty;
  logic   full;
  logic   bypass;
  logic   pop;
  logic   push;
  logic   pair;
  logic   overflow_evt;
  logic   underflow_evt;

  assign grm_in = '{result: grm_result, rd_wen: grm_rd_wen, rd_addr: grm_rd_addr, rd_data: grm_rd_data};
  assign dut_in = '{result: dut_result, rd_wen: dut_rd_wen, rd_addr: dut_rd_addr, rd_data: dut_rd_data};

  always_comb begin
    empty         = (count == '0);
    full          = (count == PFULL);
    // An empty FIFO with both results arriving together pairs them directly,
    // so the GRM entry never touches the FIFO.
    bypass        = empty && grm_out_valid && dut_out_valid;
    pop           = !empty && dut_out_valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push          = grm_out_valid && !bypass && (!full || pop);
    pair          = pop || bypass;
    overflow_evt  = grm_out_valid && full && !pop;
    underflow_evt = dut_out_valid && empty && !grm_out_valid;
    pair_grm      = bypass ? grm_in : mem[rd_ptr];

    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + PW'(1);
    end else if (pop && !push) begin
      count_nxt = count - PW'(1);
    end

    // The wait counter measures how long the current head has been waiting.
    wait_nxt = wait_cnt;
    if (empty || pop) begin
      wait_nxt = '0;
    end else if (wait_cnt != TMAX) begin
      wait_nxt = wait_cnt + TW'(1);
    end
  end

  // Storage is not reset. Contents are meaningless while count is 0.
  always_ff @(posedge g_clk) begin
    if (push) begin
      mem[wr_ptr] <= grm_in;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      wait_cnt      <= '0;
      chk_valid     <= 1'b0;
      chk_dut_q     <= '0;
      chk_grm_q     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      wait_cnt  <= wait_nxt;
      chk_valid <= pair;
      if (pair) begin
        chk_dut_q <= dut_in;
        chk_grm_q <= pair_grm;
      end
      if (overflow_evt) begin
        err_overflow <= 1'b1;
      end
      if (underflow_evt) begin
        err_underflow <= 1'b1;
      end
      // The flag is raised one edge after the counter sits at TIMEOUT.
      if (wait_cnt == TMAX) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign pending         = count;
  assign chk_dut_result  = chk_dut_q.result;
  assign chk_dut_rd_wen  = chk_dut_q.rd_wen;
  assign chk_dut_rd_addr = chk_dut_q.rd_addr;
  assign chk_dut_rd_data = chk_dut_q.rd_data;
  assign chk_grm_result  = chk_grm_q.result;
  assign chk_grm_rd_wen  = chk_grm_q.rd_wen;
  assign chk_grm_rd_addr = chk_grm_q.rd_addr;
  assign chk_grm_rd_data = chk_grm_q.rd_data;

endmodule

// File: tb/tb_model_output_aligner.sv
// Testbench for model_output_aligner (DEPTH=4, TIMEOUT=8).
// A reference model keeps GRM results in a queue, pairs them with DUT
// results in arrival order and tracks how long the oldest entry has waited.
module tb_model_output_aligner;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset / DUT ----------------
  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        grm_out_valid = 1'b0;
  logic [2:0]  grm_result = '0;
  logic        grm_rd_wen = 1'b0;
  logic [4:0]  grm_rd_addr = '0;
  logic [31:0] grm_rd_data = '0;
  logic        dut_out_valid = 1'b0;
  logic [2:0]  dut_result = '0;
  logic        dut_rd_wen = 1'b0;
  logic [4:0]  dut_rd_addr = '0;
  logic [31:0] dut_rd_data = '0;
  logic        chk_valid;
  logic [2:0]  chk_dut_result;
  logic        chk_dut_rd_wen;
  logic [4:0]  chk_dut_rd_addr;
  logic [31:0] chk_dut_rd_data;
  logic [2:0]  chk_grm_result;
  logic        chk_grm_rd_wen;
  logic [4:0]  chk_grm_rd_addr;
  logic [31:0] chk_grm_rd_data;
  logic [2:0]  pending;
  logic        err_overflow;
  logic        err_underflow;
  logic        err_timeout;

  always #5 g_clk = ~g_clk;

  model_output_aligner #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .grm_out_valid(grm_out_valid), .grm_result(grm_result), .grm_rd_wen(grm_rd_wen),
    .grm_rd_addr(grm_rd_addr), .grm_rd_data(grm_rd_data),
    .dut_out_valid(dut_out_valid), .dut_result(dut_result), .dut_rd_wen(dut_rd_wen),
    .dut_rd_addr(dut_rd_addr), .dut_rd_data(dut_rd_data),
    .chk_valid(chk_valid),
    .chk_dut_result(chk_dut_result), .chk_dut_rd_wen(chk_dut_rd_wen),
    .chk_dut_rd_addr(chk_dut_rd_addr), .chk_dut_rd_data(chk_dut_rd_data),
    .chk_grm_result(chk_grm_result), .chk_grm_rd_wen(chk_grm_rd_wen),
    .chk_grm_rd_addr(chk_grm_rd_addr), .chk_grm_rd_data(chk_grm_rd_data),
    .pending(pending),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  wire [40:0] obs_grm = {chk_grm_result, chk_grm_rd_wen, chk_grm_rd_addr, chk_grm_rd_data};
  wire [40:0] obs_dut = {chk_dut_result, chk_dut_rd_wen, chk_dut_rd_addr, chk_dut_rd_data};
  wire [2:0]  obs_err = {err_overflow, err_underflow, err_timeout};

  // ---------------- reference model / scoreboard ----------------
  logic [40:0] exp_q[$];      // GRM entries waiting for a DUT result
  logic        exp_valid;
  logic [40:0] exp_grm;
  logic [40:0] exp_dut;
  int          exp_age;       // cycles the oldest entry has waited
  logic        exp_ovf;
  logic        exp_unf;
  logic        exp_to;

  int checks = 0;
  int errors = 0;

  function automatic logic [40:0] mk(input logic [31:0] data);
    return {3'd1, 1'b1, 5'd5, data};
  endfunction

  function automatic logic [40:0] rnd_entry();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[40:0];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_grm   = '0;
    exp_dut   = '0;
    exp_age   = 0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
    exp_to    = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    g_resetn      = 1'b0;
    grm_out_valid = 1'b0;
    dut_out_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
  endtask

  // Drives one cycle, updates the model, and returns 1 time unit after the edge.
  task automatic step(input logic gv, input logic [40:0] g, input logic dv, input logic [40:0] d);
    logic was_empty;
    logic popped;
    grm_out_valid = gv;
    {grm_result, grm_rd_wen, grm_rd_addr, grm_rd_data} = g;
    dut_out_valid = dv;
    {dut_result, dut_rd_wen, dut_rd_addr, dut_rd_data} = d;
    was_empty = (exp_q.size() == 0);
    popped    = 1'b0;
    exp_valid = 1'b0;
    if (exp_age == TIMEOUT) exp_to = 1'b1;
    if (gv && dv && was_empty) begin
      exp_valid = 1'b1;
      exp_grm   = g;
      exp_dut   = d;
    end else begin
      if (dv && !was_empty) begin
        exp_valid = 1'b1;
        exp_grm   = exp_q.pop_front();
        exp_dut   = d;
        popped    = 1'b1;
      end
      if (dv && was_empty) exp_unf = 1'b1;
      if (gv) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(g);
        else exp_ovf = 1'b1;
      end
    end
    if (was_empty || popped) exp_age = 0;
    else if (exp_age < TIMEOUT) exp_age++;
    @(posedge g_clk);
    #1;
    grm_out_valid = 1'b0;
    dut_out_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", chk_valid); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d exp 0", pending); end
    checks++; if (obs_err !== 3'b000) begin errors++; $display("FAIL reset_errs got %b exp 000", obs_err); end
    checks++; if (obs_grm !== 41'd0 || obs_dut !== 41'd0) begin
      errors++; $display("FAIL reset_data got grm %h dut %h exp 0", obs_grm, obs_dut);
    end
  endtask

  task automatic test_bypass();
    step(1'b1, mk(32'h1234_5678), 1'b1, mk(32'h1234_5678));
    checks++; if (chk_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b exp 1", chk_valid); end
    checks++; if (chk_grm_rd_data !== 32'h1234_5678 || chk_dut_rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_data got grm %h dut %h exp 12345678", chk_grm_rd_data, chk_dut_rd_data);
    end
    checks++; if (chk_grm_rd_addr !== 5'd5 || chk_grm_rd_wen !== 1'b1) begin
      errors++; $display("FAIL bypass_fields got addr %0d wen %b exp 5 1", chk_grm_rd_addr, chk_grm_rd_wen);
    end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL bypass_pending got %0d exp 0", pending); end
    step(1'b0, '0, 1'b0, '0);
    checks++; if (chk_valid !== 1'b0) begin errors++; $display("FAIL bypass_pulse got %b exp 0", chk_valid); end
    checks++; if (chk_grm_rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL bypass_hold got %h exp 12345678", chk_grm_rd_data);
    end
  endtask

  task automatic test_ordering();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(32'(8'h11 * (i + 1))), 1'b0, '0);
      checks++; if (pending !== 3'(i + 1)) begin errors++; $display("FAIL order_fill got %0d exp %0d", pending, i + 1); end
    end
    repeat (2) step(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, rnd_entry());
      checks++; if (chk_valid !== 1'b1 || chk_grm_rd_data !== 32'(8'h11 * (i + 1))) begin
        errors++; $display("FAIL order_pop got v%b %h exp v1 %h", chk_valid, chk_grm_rd_data, 32'(8'h11 * (i + 1)));
      end
      checks++; if (obs_dut !== exp_dut) begin errors++; $display("FAIL order_dut got %h exp %h", obs_dut, exp_dut); end
      checks++; if (pending !== 3'(2 - i)) begin errors++; $display("FAIL order_drain got %0d exp %0d", pending, 2 - i); end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, mk(32'(i)), 1'b0, '0);
      if (i == 4) begin
        checks++; if (err_overflow !== 1'b0 || pending !== 3'd4) begin
          errors++; $display("FAIL ovf_full got ovf %b pend %0d exp 0 4", err_overflow, pending);
        end
      end
    end
    checks++; if (err_overflow !== 1'b1 || pending !== 3'd4) begin
      errors++; $display("FAIL ovf_set got ovf %b pend %0d exp 1 4", err_overflow, pending);
    end
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1, rnd_entry());
      checks++; if (chk_valid !== 1'b1 || chk_grm_rd_data !== 32'(i)) begin
        errors++; $display("FAIL ovf_pop got v%b %h exp v1 %h", chk_valid, chk_grm_rd_data, 32'(i));
      end
    end
    checks++; if (pending !== 3'd0 || err_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_end got pend %0d ovf %b exp 0 1", pending, err_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 1; i <= 4; i++) step(1'b1, mk(32'(i)), 1'b0, '0);
    step(1'b1, mk(32'h55), 1'b1, rnd_entry());
    checks++; if (pending !== 3'd4 || err_overflow !== 1'b0 || chk_grm_rd_data !== 32'd1) begin
      errors++; $display("FAIL fullpp got pend %0d ovf %b d %h exp 4 0 1", pending, err_overflow, chk_grm_rd_data);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, rnd_entry());
      checks++; if (obs_grm !== exp_grm || chk_valid !== 1'b1) begin
        errors++; $display("FAIL fullpp_drain got %h exp %h", obs_grm, exp_grm);
      end
    end
    checks++; if (chk_grm_rd_data !== 32'h55) begin errors++; $display("FAIL fullpp_last got %h exp 55", chk_grm_rd_data); end
  endtask

  task automatic test_underflow();
    apply_reset();
    step(1'b0, '0, 1'b1, rnd_entry());
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", err_underflow); end
    checks++; if (chk_valid !== 1'b0 || pending !== 3'd0) begin
      errors++; $display("FAIL unf_state got v%b pend %0d exp v0 0", chk_valid, pending);
    end
    step(1'b1, mk(32'h77), 1'b0, '0);
    checks++; if (pending !== 3'd1 || err_underflow !== 1'b1) begin
      errors++; $display("FAIL unf_sticky got pend %0d unf %b exp 1 1", pending, err_underflow);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    step(1'b1, mk(32'h99), 1'b0, '0);
    repeat (8) step(1'b0, '0, 1'b0, '0);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", err_timeout); end
    step(1'b0, '0, 1'b0, '0);
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", err_timeout); end
    step(1'b0, '0, 1'b1, rnd_entry());
    checks++; if (chk_valid !== 1'b1 || err_timeout !== 1'b1) begin
      errors++; $display("FAIL to_nostall got v%b to %b exp 1 1", chk_valid, err_timeout);
    end
    // control: result arrives while the head has waited 7 cycles
    apply_reset();
    step(1'b1, mk(32'h98), 1'b0, '0);
    repeat (7) step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, rnd_entry());
    checks++; if (chk_valid !== 1'b1 || chk_grm_rd_data !== 32'h98) begin
      errors++; $display("FAIL to_ctl_pop got v%b %h exp v1 98", chk_valid, chk_grm_rd_data);
    end
    repeat (4) step(1'b0, '0, 1'b0, '0);
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_ctl got %b exp 0", err_timeout); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b1, mk(32'(i + 40)), 1'b0, '0);
    step(1'b1, mk(32'h43), 1'b1, rnd_entry());
    checks++; if (pending !== 3'd3 || chk_valid !== 1'b1) begin
      errors++; $display("FAIL ar_pre got pend %0d v%b exp 3 1", pending, chk_valid);
    end
    #3;
    g_resetn = 1'b0;
    model_reset();
    #1;
    checks++; if (pending !== 3'd0 || chk_valid !== 1'b0 || chk_grm_rd_data !== 32'd0) begin
      errors++; $display("FAIL ar_now got pend %0d v%b d %h exp 0 0 0", pending, chk_valid, chk_grm_rd_data);
    end
    grm_out_valid = 1'b1;
    dut_out_valid = 1'b1;
    @(posedge g_clk);
    #1;
    checks++; if (pending !== 3'd0 || chk_valid !== 1'b0) begin
      errors++; $display("FAIL ar_ignore got pend %0d v%b exp 0 0", pending, chk_valid);
    end
    grm_out_valid = 1'b0;
    dut_out_valid = 1'b0;
    g_resetn = 1'b1;
    step(1'b1, mk(32'hAB), 1'b1, mk(32'hCD));
    checks++; if (chk_valid !== 1'b1 || chk_grm_rd_data !== 32'hAB || chk_dut_rd_data !== 32'hCD || pending !== 3'd0) begin
      errors++; $display("FAIL ar_bypass got v%b g %h d %h p %0d exp 1 ab cd 0", chk_valid, chk_grm_rd_data, chk_dut_rd_data, pending);
    end
  endtask

  task automatic test_random();
    int gp;
    int dp;
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      // alternate fill-heavy, drain-heavy and balanced phases
      case ((n / 50) % 3)
        0:       begin gp = 70; dp = 25; end
        1:       begin gp = 25; dp = 70; end
        default: begin gp = 50; dp = 50; end
      endcase
      step($urandom_range(0, 99) < gp, rnd_entry(), $urandom_range(0, 99) < dp, rnd_entry());
      checks++; if (chk_valid !== exp_valid || pending !== 3'(exp_q.size())) begin
        errors++; $display("FAIL rnd_ctl n=%0d got v%b p%0d exp v%b p%0d", n, chk_valid, pending, exp_valid, exp_q.size());
      end
      checks++; if (obs_err !== {exp_ovf, exp_unf, exp_to}) begin
        errors++; $display("FAIL rnd_err n=%0d got %b exp %b", n, obs_err, {exp_ovf, exp_unf, exp_to});
      end
      if (exp_valid) begin
        checks++; if (obs_grm !== exp_grm || obs_dut !== exp_dut) begin
          errors++; $display("FAIL rnd_data n=%0d got %h/%h exp %h/%h", n, obs_grm, obs_dut, exp_grm, exp_dut);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_bypass();
    test_ordering();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_timeout();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
